// File: rtl/event_queue_if.sv
// Dispatcher handshake bundle: event_queue drives transmit and the entry fields,
// and the dispatcher answers with busy.
interface event_queue_if;
  logic        transmit;
  logic        busy;
  logic [2:0]  data;
  logic [15:0] ts;
  logic [8:0]  liv_out;

  modport master (output transmit, data, ts, liv_out, input busy);
  modport slave  (input transmit, data, ts, liv_out, output busy);
endinterface

// File: rtl/event_queue.sv
// Edge-detects the monitoring event lines, stamps each event with BCD time and the
// level counter, queues it, and hands entries one at a time to the dispatcher.
module event_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_BITS = 2,
  parameter int unsigned LEV_STEP = 5,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                status,
  input  logic                history,
  input  logic                change,
  input  logic                lev,
  input  logic                clear,
  input  logic [3:0]          o_min,
  input  logic [3:0]          o_dmin,
  input  logic [3:0]          o_ore,
  input  logic [3:0]          o_dore,
  event_queue_if.master       disp,
  output logic [8:0]          livello,
  output logic [PTR_BITS:0]   count,
  output logic                overflow,
  output logic                hs_err
);

  localparam int unsigned TmrW   = $clog2(TIMEOUT + 1);
  localparam logic [9:0]  LivMax = 10'd510;

  typedef enum logic [1:0] {StIdle, StSend, StWaitHi, StWaitLo} state_e;

  // Line vector ordered by arbitration priority, highest in the MSB.
  logic [4:0] lines, prev_q, pend_q, pend_d, rise, grant;
  logic [2:0] code;
  logic       push_req, push, pop, drop, full, hs_set;
  logic [9:0] lev_sum;
  logic [8:0] livello_q, liv_new;
  logic [27:0] entry;
  logic [27:0] mem_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_BITS:0]   count_q;
  logic        overflow_q, hs_err_q;
  logic [2:0]  data_q;
  logic [15:0] ts_q;
  logic [8:0]  liv_q;
  state_e      state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;

  assign lines = {clear, status, change, history, lev};
  assign rise  = lines & ~prev_q;

  always_comb begin
    grant = '0;
    code  = '0;
    if (pend_q[4]) begin
      grant = 5'b10000;
      code  = 3'd4;
    end else if (pend_q[3]) begin
      grant = 5'b01000;
      code  = 3'd3;
    end else if (pend_q[2]) begin
      grant = 5'b00100;
      code  = 3'd2;
    end else if (pend_q[1]) begin
      grant = 5'b00010;
      code  = 3'd6;
    end else if (pend_q[0]) begin
      grant = 5'b00001;
      code  = 3'd1;
    end
  end

  // An edge on a line whose bit is still pending simply merges into it.
  assign pend_d   = (pend_q & ~grant) | rise;
  assign push_req = |pend_q;

  assign lev_sum = {1'b0, livello_q} + 10'(LEV_STEP);
  always_comb begin
    liv_new = livello_q;
    if (grant[4]) begin
      liv_new = '0;
    end else if (grant[0]) begin
      liv_new = (lev_sum > LivMax) ? LivMax[8:0] : lev_sum[8:0];
    end
  end

  assign entry = {code, o_dore, o_ore, o_dmin, o_min, liv_new};
  assign full  = (count_q == (PTR_BITS + 1)'(DEPTH));
  assign pop   = (state_q == StIdle) && (count_q != '0) && !disp.busy;
  assign push  = push_req && (!full || pop);
  assign drop  = push_req && full && !pop;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    hs_set  = 1'b0;
    unique case (state_q)
      StIdle: if (pop) state_d = StSend;
      StSend: begin
        tmr_d   = '0;
        state_d = StWaitHi;
      end
      StWaitHi: begin
        if (disp.busy) begin
          state_d = StWaitLo;
        end else if (tmr_q == TmrW'(TIMEOUT - 1)) begin
          hs_set  = 1'b1;
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StWaitLo: if (!disp.busy) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= lines;
      pend_q     <= '0;
      livello_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      hs_err_q   <= 1'b0;
      data_q     <= '0;
      ts_q       <= '0;
      liv_q      <= '0;
      state_q    <= StIdle;
      tmr_q      <= '0;
    end else begin
      prev_q     <= lines;
      pend_q     <= pend_d;
      overflow_q <= overflow_q | drop;
      hs_err_q   <= hs_err_q | hs_set;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      if (push) begin
        wr_ptr_q  <= wr_ptr_q + 1'b1;
        livello_q <= liv_new;
      end
      if (pop) begin
        {data_q, ts_q, liv_q} <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign disp.transmit = (state_q == StSend);
  assign disp.data     = data_q;
  assign disp.ts       = ts_q;
  assign disp.liv_out  = liv_q;
  assign livello       = livello_q;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign hs_err        = hs_err_q;

endmodule

// File: tb/tb_event_queue.sv
// Directed bench for event_queue: reset, latency, priority, overflow, saturation and
// handshake timeout, with hand-computed expectations.
module tb_event_queue;

  logic       clk, rst;
  logic       status, history, change, lev, clear;
  logic [3:0] o_min, o_dmin, o_ore, o_dore;
  logic [8:0] livello;
  logic [2:0] count;
  logic       overflow, hs_err;
  int         vecs, errs, lev_bad;
  bit         seen;

  event_queue_if disp ();

  event_queue dut (
    .clk      (clk),
    .rst      (rst),
    .status   (status),
    .history  (history),
    .change   (change),
    .lev      (lev),
    .clear    (clear),
    .o_min    (o_min),
    .o_dmin   (o_dmin),
    .o_ore    (o_ore),
    .o_dore   (o_dore),
    .disp     (disp),
    .livello  (livello),
    .count    (count),
    .overflow (overflow),
    .hs_err   (hs_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tx(input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      tick();
      if (disp.transmit === 1'b1) found = 1'b1;
    end
  endtask

  task automatic pulse_busy(input int n);
    disp.busy = 1'b1;
    repeat (n) tick();
    disp.busy = 1'b0;
  endtask

  logic [2:0] exp_d3 [3];
  logic [8:0] exp_l3 [3];
  logic [2:0] exp_d4 [4];

  initial begin
    vecs = 0;
    errs = 0;
    exp_d3 = '{3'd4, 3'd2, 3'd1};
    exp_l3 = '{9'd0, 9'd0, 9'd5};
    exp_d4 = '{3'd4, 3'd3, 3'd2, 3'd6};
    {status, history, change, lev, clear} = '0;
    {o_dore, o_ore, o_dmin, o_min} = 16'h0000;
    disp.busy = 1'b0;

    // Line high across reset release must not produce an event.
    rst = 1'b1;
    status = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_transmit", 32'(disp.transmit), 32'd0);
    check("rst_livello", 32'(livello), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_hs_err", 32'(hs_err), 32'd0);
    status = 1'b0;
    tick();

    // Single lev edge: push after two edges, transmit on the third.
    {o_dore, o_ore, o_dmin, o_min} = 16'h1234;
    lev = 1'b1;
    tick();
    check("lat_pending_count", 32'(count), 32'd0);
    tick();
    check("lat_push_count", 32'(count), 32'd1);
    check("lat_tx_early", 32'(disp.transmit), 32'd0);
    tick();
    check("lat_tx", 32'(disp.transmit), 32'd1);
    check("lev_data", 32'(disp.data), 32'd1);
    check("lev_liv_out", 32'(disp.liv_out), 32'd5);
    check("lev_ts", 32'(disp.ts), 32'h1234);
    check("lev_livello", 32'(livello), 32'd5);
    disp.busy = 1'b1;
    tick();
    check("tx_one_cycle", 32'(disp.transmit), 32'd0);
    tick();
    disp.busy = 1'b0;
    lev = 1'b0;
    repeat (3) tick();

    // Simultaneous clear/change/lev, dispatcher busy 50 cycles per entry.
    clear = 1'b1;
    change = 1'b1;
    lev = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_tx(10, seen);
      check("sim_seen", 32'(seen), 32'd1);
      check("sim_data", 32'(disp.data), 32'(exp_d3[i]));
      check("sim_liv_out", 32'(disp.liv_out), 32'(exp_l3[i]));
      pulse_busy(50);
    end
    {clear, change, lev} = '0;
    repeat (3) tick();

    // Burst while busy: four fit, lev (fifth) and a repeated status are dropped.
    disp.busy = 1'b1;
    {status, history, change, lev, clear} = 5'b11111;
    repeat (5) tick();
    check("burst_full", 32'(count), 32'd4);
    check("burst_no_ovf_yet", 32'(overflow), 32'd0);
    tick();
    check("burst_ovf", 32'(overflow), 32'd1);
    status = 1'b0;
    tick();
    status = 1'b1;
    repeat (3) tick();
    check("burst_still_full", 32'(count), 32'd4);
    disp.busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_tx(10, seen);
      check("burst_seen", 32'(seen), 32'd1);
      check("burst_data", 32'(disp.data), 32'(exp_d4[i]));
      pulse_busy(3);
    end
    wait_tx(20, seen);
    check("burst_no_extra", 32'(seen), 32'd0);
    check("burst_empty", 32'(count), 32'd0);
    {status, history, change, lev, clear} = '0;
    repeat (2) tick();

    // 110 lev edges saturate livello at 510.
    lev_bad = 0;
    for (int i = 0; i < 110; i++) begin
      lev = 1'b1;
      wait_tx(10, seen);
      if (!seen || disp.data !== 3'd1) lev_bad++;
      pulse_busy(2);
      lev = 1'b0;
      tick();
    end
    check("sat_all_sent", 32'(lev_bad), 32'd0);
    check("sat_livello", 32'(livello), 32'd510);
    check("sat_liv_out", 32'(disp.liv_out), 32'd510);
    clear = 1'b1;
    wait_tx(10, seen);
    check("clr_seen", 32'(seen), 32'd1);
    check("clr_data", 32'(disp.data), 32'd4);
    check("clr_liv_out", 32'(disp.liv_out), 32'd0);
    check("clr_livello", 32'(livello), 32'd0);
    pulse_busy(2);
    clear = 1'b0;
    repeat (3) tick();

    // busy never rises: timeout after 16 WAIT_HI cycles, then next entry goes out.
    check("hs_pre", 32'(hs_err), 32'd0);
    change = 1'b1;
    history = 1'b1;
    wait_tx(10, seen);
    check("hs_first_seen", 32'(seen), 32'd1);
    check("hs_first_data", 32'(disp.data), 32'd2);
    repeat (16) tick();
    check("hs_not_yet", 32'(hs_err), 32'd0);
    tick();
    check("hs_set", 32'(hs_err), 32'd1);
    tick();
    check("hs_next_tx", 32'(disp.transmit), 32'd1);
    check("hs_next_data", 32'(disp.data), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
